// File: rtl/bsg_chip_io_link_pkg.sv
// Shared types for the IO link transmit arbiter: header layout and FSM state encoding.
package bsg_chip_io_link_pkg;

   localparam int hdr_width_lp     = 32;
   localparam int hdr_len_width_lp = 4;

   // Body length sits in the low bits so it lines up with the flit's LSBs.
   typedef struct packed {
      logic [hdr_width_lp-hdr_len_width_lp-1:0] payload;
      logic [hdr_len_width_lp-1:0]              len;
   } bsg_chip_io_link_hdr_s;

   typedef enum logic {e_idle, e_burst} bsg_chip_io_link_state_e;

endpackage

// File: rtl/bsg_chip_io_link_rr_pick.sv
// Combinational round-robin picker: first set candidate at or above rr_ptr_i, wrapping.
module bsg_chip_io_link_rr_pick
   import bsg_chip_io_link_pkg::*;
#(
   parameter int num_req_p    = 4,
   parameter int ptr_width_lp = $clog2(num_req_p)
)
(
   input  logic [num_req_p-1:0]    cand_i,
   input  logic [ptr_width_lp-1:0] rr_ptr_i,
   output logic [num_req_p-1:0]    grant_o,
   output logic [ptr_width_lp-1:0] idx_o,
   output logic                    found_o
);

   int k;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      k       = 0;
      for (int off = 0; off < num_req_p; off++) begin
         k = (int'(rr_ptr_i) + off) % num_req_p;
         if (!found_o && cand_i[k]) begin
            found_o = 1'b1;
            idx_o   = ptr_width_lp'(k);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_grant
         assign grant_o[gi] = found_o && (int'(idx_o) == gi);
      end
   endgenerate

endmodule

// File: rtl/bsg_chip_io_link_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the uplink core transmit port;
// a granted requester owns the link until its last body flit transfers.
module bsg_chip_io_link_tx_arbiter
   import bsg_chip_io_link_pkg::*;
#(
   parameter int num_req_p   = 4,
   parameter int width_p     = 32,
   parameter int len_width_p = 4
)
(
   input  logic                         core_clk_i,
   input  logic                         core_reset_i,
   input  logic [num_req_p-1:0]         req_en_i,
   input  logic [num_req_p-1:0]         req_v_i,
   input  logic [num_req_p*width_p-1:0] req_data_i,
   output logic [num_req_p-1:0]         req_ready_and_o,
   output logic                         link_v_o,
   output logic [width_p-1:0]           link_data_o,
   input  logic                         link_ready_and_i,
   output logic [num_req_p-1:0]         grant_o,
   output logic                         busy_o
);

   localparam int ptr_width_lp = $clog2(num_req_p);

   bsg_chip_io_link_state_e state_q, state_d;
   logic [ptr_width_lp-1:0] rr_ptr_q, rr_ptr_d;
   logic [ptr_width_lp-1:0] owner_q, owner_d;
   logic [len_width_p-1:0]  remain_q, remain_d;

   logic [width_p-1:0]      flit [num_req_p];
   logic [num_req_p-1:0]    cand, pick_grant, owner_oh;
   logic [ptr_width_lp-1:0] pick_idx;
   logic                    pick_found;
   logic                    xfer;
   logic [len_width_p-1:0]  hdr_len;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (int'(p) == num_req_p-1) ? '0 : p + 1'b1;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_req
         assign flit[gi]     = req_data_i[gi*width_p +: width_p];
         assign owner_oh[gi] = (int'(owner_q) == gi);
      end
   endgenerate

   assign cand = req_v_i & req_en_i;

   bsg_chip_io_link_rr_pick #(.num_req_p(num_req_p)) rr_pick (
      .cand_i   (cand),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (pick_grant),
      .idx_o    (pick_idx),
      .found_o  (pick_found)
   );

   // Outputs are forced low while reset is held so nothing leaks onto the link.
   always_comb begin
      grant_o     = '0;
      link_v_o    = 1'b0;
      link_data_o = '0;
      if (!core_reset_i) begin
         if (state_q == e_idle) begin
            grant_o  = pick_grant;
            link_v_o = pick_found;
            if (pick_found) link_data_o = flit[pick_idx];
         end else begin
            grant_o     = owner_oh;
            link_v_o    = req_v_i[owner_q];
            link_data_o = flit[owner_q];
         end
      end
   end

   assign req_ready_and_o = grant_o & {num_req_p{link_ready_and_i}};
   assign busy_o          = (state_q == e_burst);
   assign xfer            = link_v_o & link_ready_and_i;
   assign hdr_len         = link_data_o[len_width_p-1:0];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      remain_d = remain_q;
      case (state_q)
         e_idle: if (xfer) begin
            if (hdr_len == '0) begin
               rr_ptr_d = ptr_inc(pick_idx);
            end else begin
               state_d  = e_burst;
               owner_d  = pick_idx;
               remain_d = hdr_len;
            end
         end
         e_burst: if (xfer) begin
            remain_d = remain_q - 1'b1;
            if (remain_q == len_width_p'(1)) begin
               state_d  = e_idle;
               rr_ptr_d = ptr_inc(owner_q);
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge core_clk_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         state_q  <= e_idle;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         remain_q <= remain_d;
      end
   end

   a_grant_onehot: assert property (@(posedge core_clk_i) disable iff (core_reset_i)
      $onehot0(grant_o));
   a_data_stable: assert property (@(posedge core_clk_i) disable iff (core_reset_i)
      (link_v_o && !link_ready_and_i) |=> $stable(link_data_o));

endmodule

// File: tb/tb_bsg_chip_io_link_tx_arbiter.sv
// Bench for the IO link transmit arbiter: table-driven cycles plus burst, stall and reset sequences.
module tb_bsg_chip_io_link_tx_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk, rst;
   logic [N-1:0]   req_en, req_v, req_ready, grant;
   logic [N*W-1:0] req_data;
   logic           link_v, link_ready, busy;
   logic [W-1:0]   link_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [N-1:0] g;
      logic [W-1:0] d;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct packed {
      logic [3:0] v;
      logic [3:0] en;
      logic       rdy;
      logic [3:0] eg;
      logic       ev;
      logic       eb;
      logic [7:0] tag;
   } vec_t;
   vec_t tbl [15];

   bsg_chip_io_link_tx_arbiter #(.num_req_p(N), .width_p(W), .len_width_p(4)) dut (
      .core_clk_i       (clk),
      .core_reset_i     (rst),
      .req_en_i         (req_en),
      .req_v_i          (req_v),
      .req_data_i       (req_data),
      .req_ready_and_o  (req_ready),
      .link_v_o         (link_v),
      .link_data_o      (link_data),
      .link_ready_and_i (link_ready),
      .grant_o          (grant),
      .busy_o           (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] mk(input logic [7:0] tag, input int i, input logic [3:0] len);
      return {tag, 8'(i), 12'h5A5, len};
   endfunction

   function automatic int oh2idx(input logic [N-1:0] oh);
      int r = 0;
      for (int i = 0; i < N; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
   task automatic cyc(input string nm, input logic [3:0] v, input logic [3:0] en, input logic rdy,
                      input logic [15:0] lens, input logic [7:0] tag,
                      input logic [3:0] eg, input logic ev, input logic eb);
      int idx;
      logic [W-1:0] ed;
      req_v      = v;
      req_en     = en;
      link_ready = rdy;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = mk(tag, i, lens[i*4 +: 4]);
      idx = oh2idx(eg);
      ed  = mk(tag, idx, lens[idx*4 +: 4]);
      if (ev && rdy) sb.push_back('{g: eg, d: ed});
      @(negedge clk);
      chk({nm, "_grant"}, 32'(grant), 32'(eg));
      chk({nm, "_link_v"}, 32'(link_v), 32'(ev));
      chk({nm, "_busy"}, 32'(busy), 32'(eb));
      chk({nm, "_ready"}, 32'(req_ready), 32'(eg & {4{rdy}}));
      if (ev) chk({nm, "_data"}, link_data, ed);
      $display("cycle %s: v=%b en=%b rdy=%b grant=%b link_v=%b busy=%b data=%h",
               nm, v, en, rdy, grant, link_v, busy, link_data);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every link transfer must match the oldest expected transfer.
   always @(negedge clk) begin
      if (!rst && link_v && link_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_extra: got grant %b data %h expected no transfer", grant, link_data);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_grant", 32'(grant), 32'(mon_e.g));
            chk("sb_data", link_data, mon_e.d);
         end
      end
   end

   initial begin
      //           v        en       rdy   eg       ev    eb    tag
      tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 8'd0};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 8'd1};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 8'd2};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 8'd3};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 8'd4};
      tbl[5]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd5};
      tbl[6]  = '{4'b1111, 4'b1011, 1'b1, 4'b0010, 1'b1, 1'b0, 8'd6};
      tbl[7]  = '{4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b0, 8'd7};
      tbl[8]  = '{4'b1111, 4'b1011, 1'b1, 4'b0001, 1'b1, 1'b0, 8'd8};
      tbl[9]  = '{4'b1111, 4'b1011, 1'b1, 4'b0010, 1'b1, 1'b0, 8'd9};
      tbl[10] = '{4'b1111, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b0, 8'd10};
      tbl[11] = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 8'd11};
      tbl[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 8'd11};
      tbl[13] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 8'd13};
      tbl[14] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd14};

      rst        = 1'b1;
      req_v      = 4'b1111;
      req_en     = 4'b1111;
      link_ready = 1'b1;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = mk(8'hFF, i, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_link_v", 32'(link_v), 32'd0);
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      for (int r = 0; r < 15; r++)
         cyc($sformatf("tbl%0d", r), tbl[r].v, tbl[r].en, tbl[r].rdy, 16'h0000, tbl[r].tag,
             tbl[r].eg, tbl[r].ev, tbl[r].eb);

      // Requester 2, len=3: header plus three body flits; pointer then sits at 3.
      cyc("A_hdr", 4'b0100, 4'b1111, 1'b1, 16'h0300, 8'h20, 4'b0100, 1'b1, 1'b0);
      cyc("A_b1",  4'b0100, 4'b1111, 1'b1, 16'h0000, 8'h21, 4'b0100, 1'b1, 1'b1);
      cyc("A_b2",  4'b0100, 4'b1111, 1'b1, 16'h0000, 8'h22, 4'b0100, 1'b1, 1'b1);
      cyc("A_b3",  4'b0100, 4'b1111, 1'b1, 16'h0000, 8'h23, 4'b0100, 1'b1, 1'b1);
      cyc("A_rr3", 4'b1111, 4'b1111, 1'b1, 16'h0000, 8'h24, 4'b1000, 1'b1, 1'b0);

      // Uplink stall mid-burst, then a bubble from the owner.
      cyc("B_hdr", 4'b0001, 4'b1111, 1'b1, 16'h0002, 8'h30, 4'b0001, 1'b1, 1'b0);
      for (int s = 0; s < 5; s++)
         cyc("B_stall", 4'b0001, 4'b1111, 1'b0, 16'h0000, 8'h31, 4'b0001, 1'b1, 1'b1);
      cyc("B_b1",     4'b0001, 4'b1111, 1'b1, 16'h0000, 8'h31, 4'b0001, 1'b1, 1'b1);
      cyc("B_bubble", 4'b0000, 4'b1111, 1'b1, 16'h0000, 8'h34, 4'b0001, 1'b0, 1'b1);
      cyc("B_b2",     4'b0001, 4'b1111, 1'b1, 16'h0000, 8'h35, 4'b0001, 1'b1, 1'b1);
      cyc("B_idle",   4'b0000, 4'b1111, 1'b1, 16'h0000, 8'h36, 4'b0000, 1'b0, 1'b0);

      // Requester 1 bursts while 0 waits; enable dropped mid-burst does not abort.
      cyc("C_hdr", 4'b0011, 4'b1111, 1'b1, 16'h0020, 8'h40, 4'b0010, 1'b1, 1'b0);
      cyc("C_b1",  4'b0011, 4'b1101, 1'b1, 16'h0000, 8'h41, 4'b0010, 1'b1, 1'b1);
      cyc("C_b2",  4'b0011, 4'b1101, 1'b1, 16'h0000, 8'h42, 4'b0010, 1'b1, 1'b1);
      cyc("C_r0",  4'b0001, 4'b1101, 1'b1, 16'h0000, 8'h43, 4'b0001, 1'b1, 1'b0);

      // Reset while requester 3 still has five body flits outstanding.
      cyc("D_hdr", 4'b1000, 4'b1111, 1'b1, 16'h7000, 8'h50, 4'b1000, 1'b1, 1'b0);
      cyc("D_b1",  4'b1000, 4'b1111, 1'b1, 16'h0000, 8'h51, 4'b1000, 1'b1, 1'b1);
      cyc("D_b2",  4'b1000, 4'b1111, 1'b1, 16'h0000, 8'h52, 4'b1000, 1'b1, 1'b1);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = mk(8'h53, i, 4'd0);
      rst = 1'b1;
      #1;
      chk("D_rst_link_v", 32'(link_v), 32'd0);
      chk("D_rst_grant", 32'(grant), 32'd0);
      chk("D_rst_ready", 32'(req_ready), 32'd0);
      chk("D_rst_busy", 32'(busy), 32'd0);
      $display("cycle D_rst: link_v=%b grant=%b busy=%b", link_v, grant, busy);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("D_after", 4'b1111, 4'b1111, 1'b1, 16'h0000, 8'h54, 4'b0001, 1'b1, 1'b0);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
